// File: rtl/unit_clause_detector.sv
// Unit clause detector: one pass over the clause database per start.
// Each clause is classified against the current assignment plus the
// implications already produced in this pass. Unit clauses push their
// implied literal into the imply stack. An all-false clause aborts the pass.
module unit_clause_detector #(
  parameter int NUM_VARIABLE     = 128,
  parameter int VAR_BITS         = 9,
  parameter int LITS_PER_CLAUSE  = 5,
  parameter int CLAUSE_ADDR_BITS = 10
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [CLAUSE_ADDR_BITS-1:0]               num_clauses,
  input  logic [NUM_VARIABLE-1:0]                   assigned,
  input  logic [NUM_VARIABLE-1:0]                   assign_val,
  output logic [CLAUSE_ADDR_BITS-1:0]               clause_addr,
  input  logic [LITS_PER_CLAUSE*(VAR_BITS+1)-1:0]   clause_data,
  output logic                                      stack_en,
  output logic                                      stack_rw,
  output logic                                      stack_val,
  output logic [VAR_BITS-1:0]                       stack_variable,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      conflict,
  output logic [CLAUSE_ADDR_BITS-1:0]               conflict_clause,
  output logic [VAR_BITS-1:0]                       implied_count
);

  localparam int LIT_BITS = VAR_BITS + 1;
  localparam int IDX_BITS = $clog2(NUM_VARIABLE);
  localparam int CNT_BITS = $clog2(LITS_PER_CLAUSE + 1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_PUSH, S_DONE} state_t;
  typedef enum logic [1:0] {C_SAT, C_CONFLICT, C_UNIT, C_OPEN} clause_class_t;

  state_t                      state;
  clause_class_t               cls;
  logic [CLAUSE_ADDR_BITS-1:0] idx;
  logic [CLAUSE_ADDR_BITS-1:0] num_reg;
  logic [NUM_VARIABLE-1:0]     pending;
  logic [NUM_VARIABLE-1:0]     pend_val;
  logic                        last;

  // Classification scratch signals
  logic [VAR_BITS-1:0]         lit_var;
  logic                        lit_pol;
  logic [IDX_BITS-1:0]         lit_idx;
  logic                        eff_asg;
  logic                        eff_val;
  logic                        any_true;
  logic [CNT_BITS-1:0]         n_empty;
  logic [CNT_BITS-1:0]         n_unassigned;
  logic [VAR_BITS-1:0]         unit_var;
  logic                        unit_pol;

  assign last = (idx == num_reg - CLAUSE_ADDR_BITS'(1));

  // Evaluate every literal slot of the clause on the memory output and classify it
  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latches).
    lit_var      = '0;
    lit_pol      = 1'b0;
    lit_idx      = '0;
    eff_asg      = 1'b0;
    eff_val      = 1'b0;
    any_true     = 1'b0;
    n_empty      = '0;
    n_unassigned = '0;
    unit_var     = '0;
    unit_pol     = 1'b0;
    for (int k = 0; k < LITS_PER_CLAUSE; k++) begin
      // NOTE: blocking assignments here, because later iterations read the values just computed.
      lit_var = clause_data[k*LIT_BITS +: VAR_BITS];
      lit_pol = clause_data[k*LIT_BITS + VAR_BITS];
      if (lit_var == '0 || lit_var >= VAR_BITS'(NUM_VARIABLE)) begin
        n_empty = n_empty + CNT_BITS'(1);
      end else begin
        lit_idx = lit_var[IDX_BITS-1:0];
        eff_asg = assigned[lit_idx] | pending[lit_idx];
        eff_val = pending[lit_idx] ? pend_val[lit_idx] : assign_val[lit_idx];
        if (eff_asg) begin
          if (eff_val == lit_pol) any_true = 1'b1;
        end else begin
          n_unassigned = n_unassigned + CNT_BITS'(1);
          unit_var     = lit_var;
          unit_pol     = lit_pol;
        end
      end
    end
    if (any_true || n_empty == CNT_BITS'(LITS_PER_CLAUSE)) cls = C_SAT;
    else if (n_unassigned == '0)                           cls = C_CONFLICT;
    else if (n_unassigned == CNT_BITS'(1))                 cls = C_UNIT;
    else                                                   cls = C_OPEN;
  end

  // Pass sequencer with registered outputs; stack outputs are valid exactly during PUSH
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the pending bitmaps are plain flops, so they are cleared here along with the FSM.
      state           <= S_IDLE;
      idx             <= '0;
      num_reg         <= '0;
      pending         <= '0;
      pend_val        <= '0;
      clause_addr     <= '0;
      stack_en        <= 1'b0;
      stack_rw        <= 1'b0;
      stack_val       <= 1'b0;
      stack_variable  <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      conflict        <= 1'b0;
      conflict_clause <= '0;
      implied_count   <= '0;
    end else begin
      stack_en       <= 1'b0;
      stack_rw       <= 1'b0;
      stack_val      <= 1'b0;
      stack_variable <= '0;
      done           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pending         <= '0;
            pend_val        <= '0;
            implied_count   <= '0;
            conflict        <= 1'b0;
            conflict_clause <= '0;
            idx             <= '0;
            num_reg         <= num_clauses;
            busy            <= 1'b1;
            if (num_clauses == '0) begin
              state <= S_DONE;
            end else begin
              clause_addr <= '0;
              state       <= S_READ;
            end
          end
        end
        S_READ: state <= S_EVAL;
        S_EVAL: begin
          case (cls)
            C_UNIT: begin
              stack_en       <= 1'b1;
              stack_rw       <= 1'b1;
              stack_val      <= unit_pol;
              stack_variable <= unit_var;
              state          <= S_PUSH;
            end
            C_CONFLICT: begin
              conflict        <= 1'b1;
              conflict_clause <= idx;
              state           <= S_DONE;
            end
            default: begin
              if (last) begin
                state <= S_DONE;
              end else begin
                idx         <= idx + CLAUSE_ADDR_BITS'(1);
                clause_addr <= idx + CLAUSE_ADDR_BITS'(1);
                state       <= S_READ;
              end
            end
          endcase
        end
        S_PUSH: begin
          pending[stack_variable[IDX_BITS-1:0]]  <= 1'b1;
          pend_val[stack_variable[IDX_BITS-1:0]] <= stack_val;
          implied_count <= implied_count + VAR_BITS'(1);
          if (last) begin
            state <= S_DONE;
          end else begin
            idx         <= idx + CLAUSE_ADDR_BITS'(1);
            clause_addr <= idx + CLAUSE_ADDR_BITS'(1);
            state       <= S_READ;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unit_clause_detector.sv
// Self-checking bench for unit_clause_detector: a table of passes, a push
// scoreboard, and a hand-written reset-during-push sequence.
module tb_unit_clause_detector;

  localparam int NV  = 128;
  localparam int VB  = 9;
  localparam int LPC = 5;
  localparam int CAB = 10;
  localparam int LW  = VB + 1;
  localparam int CW  = LPC * LW;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [CAB-1:0] num_clauses;
  logic [NV-1:0]  assigned;
  logic [NV-1:0]  assign_val;
  logic [CAB-1:0] clause_addr;
  logic [CW-1:0]  clause_data;
  logic           stack_en;
  logic           stack_rw;
  logic           stack_val;
  logic [VB-1:0]  stack_variable;
  logic           busy;
  logic           done;
  logic           conflict;
  logic [CAB-1:0] conflict_clause;
  logic [VB-1:0]  implied_count;

  unit_clause_detector #(
    .NUM_VARIABLE(NV), .VAR_BITS(VB), .LITS_PER_CLAUSE(LPC), .CLAUSE_ADDR_BITS(CAB)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_clauses(num_clauses),
    .assigned(assigned), .assign_val(assign_val), .clause_addr(clause_addr),
    .clause_data(clause_data), .stack_en(stack_en), .stack_rw(stack_rw),
    .stack_val(stack_val), .stack_variable(stack_variable), .busy(busy),
    .done(done), .conflict(conflict), .conflict_clause(conflict_clause),
    .implied_count(implied_count)
  );

  always #5 clock = ~clock;

  // Synchronous clause memory: data valid the cycle after the address
  logic [CW-1:0] mem [0:(1<<CAB)-1];
  always @(posedge clock) clause_data <= mem[clause_addr];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Push scoreboard: expectations queued with the stimulus, popped on each push
  typedef struct packed {
    logic [VB-1:0] v;
    logic          b;
  } push_t;
  push_t exp_q[$];
  int    max_addr;

  always @(negedge clock) begin
    if (stack_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_push actual=var%0d/val%0d required=none", stack_variable, stack_val);
      end else begin
        push_t p;
        p = exp_q.pop_front();
        check("push", {stack_rw, stack_variable, stack_val}, {1'b1, p.v, p.b});
      end
    end
    if (busy && int'(clause_addr) > max_addr) max_addr = int'(clause_addr);
  end

  function automatic logic [LW-1:0] lit(input logic pol, input int v);
    return {pol, VB'(v)};
  endfunction

  // One table row: inputs of a pass plus everything expected from it
  typedef struct packed {
    int                 n;
    logic [NV-1:0]      asg;
    logic [NV-1:0]      aval;
    logic [3:0][CW-1:0] cl;
    int                 np;
    logic [2:0][VB-1:0] pv;
    logic [2:0]         pb;
    int                 cnt;
    logic               conf;
    int                 cc;
    int                 lat;   // clocks from the start edge until done is seen
    int                 maxa;
  } vec_t;

  vec_t vecs [8];

  task automatic run_vec(input vec_t v, input string tag);
    int k;
    for (int i = 0; i < 4; i++) mem[i] = v.cl[i];
    assigned   = v.asg;
    assign_val = v.aval;
    for (int i = 0; i < v.np; i++) exp_q.push_back({v.pv[i], v.pb[i]});
    max_addr = 0;
    @(negedge clock);
    num_clauses = CAB'(v.n);
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_busy"}, busy, 1'b1);
    k = 0;
    while (!done && k < 300) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_latency"}, k, v.lat);
    check({tag, "_conflict"}, conflict, v.conf);
    check({tag, "_conflict_clause"}, conflict_clause, v.cc);
    check({tag, "_count"}, implied_count, v.cnt);
    check({tag, "_max_addr"}, max_addr, v.maxa);
    check({tag, "_pushes_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge clock);
    check({tag, "_done_pulse_busy"}, {done, busy}, 2'b00);
  endtask

  initial begin
    vec_t v;
    int   k;
    int   done_cnt;

    for (int i = 0; i < (1 << CAB); i++) mem[i] = '0;
    reset = 1'b1; start = 1'b0; num_clauses = '0; assigned = '0; assign_val = '0;

    // 0: empty pass
    v = '0; v.n = 0; v.lat = 1; vecs[0] = v;
    // 1: {+3,-5}, x3=0 -> push x5=0
    v = '0; v.n = 1; v.asg[3] = 1'b1;
    v.cl[0] = {'0, lit(0, 5), lit(1, 3)};
    v.np = 1; v.pv[0] = 5; v.pb[0] = 1'b0; v.cnt = 1; v.lat = 4; vecs[1] = v;
    // 2: {+2},{+2,-7} -> one push, clause 1 satisfied by pending
    v = '0; v.n = 2;
    v.cl[0] = {'0, lit(1, 2)}; v.cl[1] = {'0, lit(0, 7), lit(1, 2)};
    v.np = 1; v.pv[0] = 2; v.pb[0] = 1'b1; v.cnt = 1; v.lat = 6; v.maxa = 1; vecs[2] = v;
    // 3: {+4},{-4} -> push then conflict at clause 1
    v = '0; v.n = 2;
    v.cl[0] = {'0, lit(1, 4)}; v.cl[1] = {'0, lit(0, 4)};
    v.np = 1; v.pv[0] = 4; v.pb[0] = 1'b1; v.cnt = 1;
    v.conf = 1'b1; v.cc = 1; v.lat = 6; v.maxa = 1; vecs[3] = v;
    // 4: {+1,+2} with x1=x2=0, n=3 -> conflict at clause 0, later clauses untouched
    v = '0; v.n = 3; v.asg[1] = 1'b1; v.asg[2] = 1'b1;
    v.cl[0] = {'0, lit(1, 2), lit(1, 1)}; v.cl[1] = {'0, lit(1, 9)}; v.cl[2] = {'0, lit(1, 9)};
    v.conf = 1'b1; v.cc = 0; v.lat = 3; v.maxa = 0; vecs[4] = v;
    // 5: open, satisfied by assignment, all-empty -> no action
    v = '0; v.n = 3; v.asg[12] = 1'b1;
    v.cl[0] = {'0, lit(1, 11), lit(1, 10)}; v.cl[1] = {'0, lit(0, 12)}; v.cl[2] = '0;
    v.lat = 7; v.maxa = 2; vecs[5] = v;
    // 6: out-of-range vars ignored; top legal variable 127
    v = '0; v.n = 3;
    v.cl[0] = {'0, lit(1, 20), lit(1, 200)};
    v.cl[1] = {'0, lit(1, 20), lit(0, 127)};
    v.cl[2] = {'0, lit(1, 128), lit(0, 127)};
    v.np = 2; v.pv[0] = 20; v.pb[0] = 1'b1; v.pv[1] = 127; v.pb[1] = 1'b0;
    v.cnt = 2; v.lat = 9; v.maxa = 2; vecs[6] = v;
    // 7: chained implications and a fully populated clause
    v = '0; v.n = 3;
    v.asg[30] = 1'b1; v.asg[31] = 1'b1;
    for (int i = 40; i < 44; i++) v.asg[i] = 1'b1;
    v.cl[0] = {'0, lit(1, 32), lit(1, 31), lit(1, 30)};
    v.cl[1] = {'0, lit(1, 33), lit(0, 32)};
    v.cl[2] = {lit(1, 44), lit(1, 43), lit(1, 42), lit(1, 41), lit(1, 40)};
    v.np = 3; v.pv[0] = 32; v.pb[0] = 1'b1; v.pv[1] = 33; v.pb[1] = 1'b1;
    v.pv[2] = 44; v.pb[2] = 1'b1; v.cnt = 3; v.lat = 10; v.maxa = 2; vecs[7] = v;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_outputs",
          {clause_addr, stack_en, stack_rw, stack_val, stack_variable, busy, done,
           conflict, conflict_clause, implied_count}, '0);
    @(negedge clock);
    check("idle_outputs", {busy, done, stack_en, conflict}, 4'b0000);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while a push is on the stack port
    mem[0] = {'0, lit(1, 50)}; mem[1] = {'0, lit(1, 51)}; mem[2] = {'0, lit(1, 52)};
    assigned = '0; assign_val = '0;
    exp_q.push_back({VB'(50), 1'b1});
    @(negedge clock);
    num_clauses = CAB'(3);
    start       = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (!stack_en && k < 50) begin
      @(negedge clock);
      k++;
    end
    check("rst_reach_push", stack_en, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_outputs",
          {clause_addr, stack_en, stack_rw, stack_val, stack_variable, busy, done,
           conflict, conflict_clause, implied_count}, '0);
    done_cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (done) done_cnt++;
    end
    check("rst_no_done", done_cnt, 0);
    check("rst_pushes_left", exp_q.size(), 0);
    exp_q.delete();

    run_vec(vecs[3], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
